// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: RUN/SET mode controller that issues one-cycle increment strobes to the time counters.
// Define HOLD_REPEAT_EN to build the hold-to-repeat logic on btn_inc.
module clock_set_ctrl #(
  parameter int unsigned TIMEOUT_TICKS = 30,
  parameter int unsigned REPEAT_DELAY  = 50000000,
  parameter int unsigned REPEAT_PERIOD = 10000000
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       sec_wrap,
  input  logic       min_wrap,
  output logic       sec_inc,
  output logic       min_inc,
  output logic       hr_inc,
  output logic [1:0] mode,
  output logic       blink
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } mode_t;

  localparam logic [5:0] TIMEOUT_LIMIT = 6'(TIMEOUT_TICKS);
  localparam logic [5:0] IDLE_MAX      = 6'd63;

  mode_t      state_r;
  mode_t      state_next_s;
  logic       mode_prev_r;
  logic       inc_prev_r;
  logic [5:0] idle_r;
  logic [5:0] idle_next_s;
  logic       sec_inc_r;
  logic       min_inc_r;
  logic       hr_inc_r;
  logic       blink_r;
  logic       press_mode_s;
  logic       press_inc_s;
  logic       in_set_s;
  logic       timeout_s;
  logic       rep_fire_s;
  logic       accept_inc_s;

  // Press detection, mode sequencing and saturating idle count toward timeout
  always_comb begin
    press_mode_s = btn_mode & ~mode_prev_r;
    press_inc_s  = btn_inc & ~inc_prev_r;
    in_set_s     = (state_r != RUN);
    case (state_r)
      RUN:     state_next_s = SET_HR;
      SET_HR:  state_next_s = SET_MIN;
      SET_MIN: state_next_s = SET_SEC;
      SET_SEC: state_next_s = RUN;
      default: state_next_s = RUN;
    endcase
    if (idle_r == IDLE_MAX) begin
      idle_next_s = idle_r;
    end else begin
      idle_next_s = idle_r + 6'd1;
    end
    timeout_s    = tick & (idle_next_s >= TIMEOUT_LIMIT);
    accept_inc_s = press_inc_s | rep_fire_s;
  end

  // Mode state, strobes, blink and inactivity counter
  always_ff @(posedge clk) begin
    if (clear) begin
      state_r     <= RUN;
      mode_prev_r <= 1'b1;
      inc_prev_r  <= 1'b1;
      idle_r      <= 6'd0;
      sec_inc_r   <= 1'b0;
      min_inc_r   <= 1'b0;
      hr_inc_r    <= 1'b0;
      blink_r     <= 1'b0;
    end else begin
      mode_prev_r <= btn_mode;
      inc_prev_r  <= btn_inc;
      sec_inc_r   <= 1'b0;
      min_inc_r   <= 1'b0;
      hr_inc_r    <= 1'b0;
      case (state_r)
        RUN: begin
          sec_inc_r <= tick;
          min_inc_r <= sec_wrap;
          hr_inc_r  <= min_wrap;
          idle_r    <= 6'd0;
          if (press_mode_s) begin
            state_r <= SET_HR;
            blink_r <= 1'b1;
          end else begin
            blink_r <= 1'b0;
          end
        end
        default: begin
          // Priority: mode press, then increment activity, then tick/timeout
          if (press_mode_s) begin
            state_r <= state_next_s;
            idle_r  <= 6'd0;
            blink_r <= (state_next_s != RUN);
          end else if (accept_inc_s) begin
            hr_inc_r  <= (state_r == SET_HR);
            min_inc_r <= (state_r == SET_MIN);
            sec_inc_r <= (state_r == SET_SEC);
            idle_r    <= 6'd0;
            blink_r   <= 1'b1;
          end else if (timeout_s) begin
            state_r <= RUN;
            idle_r  <= 6'd0;
            blink_r <= 1'b0;
          end else if (tick) begin
            idle_r  <= idle_next_s;
            blink_r <= ~blink_r;
          end else begin
            idle_r  <= idle_r;
          end
        end
      endcase
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam logic [31:0] DELAY_LIMIT  = 32'(REPEAT_DELAY);
  localparam logic [31:0] PERIOD_LIMIT = 32'(REPEAT_PERIOD);

  logic        hold_active_r;
  logic        repeating_r;
  logic [31:0] hold_cnt_r;
  logic [31:0] hold_limit_s;

  // First repeat waits the long delay, later ones the shorter period
  always_comb begin
    if (repeating_r) begin
      hold_limit_s = PERIOD_LIMIT;
    end else begin
      hold_limit_s = DELAY_LIMIT;
    end
    rep_fire_s = hold_active_r & btn_inc & in_set_s & ~press_mode_s &
                 (hold_cnt_r == hold_limit_s);
  end

  // Hold counter: armed by an accepted press, dropped on release or mode change
  always_ff @(posedge clk) begin
    if (clear || !btn_inc || !in_set_s || press_mode_s) begin
      hold_active_r <= 1'b0;
      repeating_r   <= 1'b0;
      hold_cnt_r    <= 32'd0;
    end else if (press_inc_s) begin
      hold_active_r <= 1'b1;
      repeating_r   <= 1'b0;
      hold_cnt_r    <= 32'd1;
    end else if (rep_fire_s) begin
      repeating_r   <= 1'b1;
      hold_cnt_r    <= 32'd1;
    end else if (hold_active_r) begin
      hold_cnt_r    <= hold_cnt_r + 32'd1;
    end else begin
      hold_cnt_r    <= hold_cnt_r;
    end
  end
`else
  logic cfg_unused_s;
  assign rep_fire_s   = 1'b0;
  assign cfg_unused_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  assign sec_inc = sec_inc_r;
  assign min_inc = min_inc_r;
  assign hr_inc  = hr_inc_r;
  assign mode    = state_r;
  assign blink   = blink_r;

endmodule
